// File: rtl/program_memory_loader.sv
// Loads a length-prefixed byte stream into program memory as big-endian 32-bit words.
// All outputs are registered and derived from the next state.
module program_memory_loader #(
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h00400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  Byte_Valid,
    input  logic [7:0]            Byte_Data,
    output logic                  Byte_Ready,
    output logic                  Write_Enable,
    output logic [DATA_WIDTH-1:0] Write_Address,
    output logic [DATA_WIDTH-1:0] Write_Data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned IdxW = $clog2(MEMORY_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e                st_q, st_d;
    logic [15:0]           n_q, n_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic [15:0]           n_new;
    logic [IdxW-1:0]       idx_inc;
    logic [DATA_WIDTH-1:0] asm_new;

    assign xfer    = Byte_Valid & rdy_q;
    assign n_new   = {n_q[15:8], Byte_Data};
    assign idx_inc = idx_q + IdxW'(1);
    assign asm_new = {asm_q[DATA_WIDTH-9:0], Byte_Data};

    always_comb begin
        st_d    = st_q;
        n_d     = n_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        unique case (st_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    st_d   = StLenHi;
                    idx_d  = '0;
                    bcnt_d = '0;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    n_d  = {Byte_Data, n_q[7:0]};
                    st_d = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    n_d = n_new;
                    if (n_new == 16'd0) begin
                        st_d = StDone;
                    end else if (32'(n_new) > MEMORY_DEPTH) begin
                        st_d = StErr;
                    end else begin
                        st_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    asm_d = asm_new;
                    if (bcnt_q == 2'd3) begin
                        // Latch the write beat now so Write_Enable is registered in WRITE.
                        bcnt_d  = '0;
                        st_d    = StWrite;
                        we_d    = 1'b1;
                        wdata_d = asm_new;
                        waddr_d = DATA_WIDTH'(BASE_ADDRESS + (32'(idx_q) << 2));
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            StWrite: begin
                idx_d = idx_inc;
                st_d  = (32'(idx_inc) == 32'(n_q)) ? StDone : StData;
            end
            default: st_d = StIdle;
        endcase

        rdy_d  = (st_d == StLenHi) || (st_d == StLenLo) || (st_d == StData);
        busy_d = rdy_d || (st_d == StWrite);
        done_d = (st_d == StDone);
        err_d  = (st_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q    <= StIdle;
            n_q     <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Byte_Ready    = rdy_q;
    assign Write_Enable  = we_q;
    assign Write_Address = waddr_q;
    assign Write_Data    = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench for program_memory_loader: expected writes queued as stimulus is driven,
// popped by a monitor whenever Write_Enable is seen.
module tb_program_memory_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        Byte_Valid;
    logic [7:0]  Byte_Data;
    logic        Byte_Ready;
    logic        Write_Enable;
    logic [31:0] Write_Address;
    logic [31:0] Write_Data;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    program_memory_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .Byte_Valid   (Byte_Valid),
        .Byte_Data    (Byte_Data),
        .Byte_Ready   (Byte_Ready),
        .Write_Enable (Write_Enable),
        .Write_Address(Write_Address),
        .Write_Data   (Write_Data),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (Write_Enable === 1'b1) begin
            logic [63:0] e;
            n_writes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%08h data=%08h, required no write",
                         Write_Address, Write_Data);
            end else begin
                e = exp_q.pop_front();
                if ({Write_Address, Write_Data} !== e) begin
                    n_bad++;
                    $display("FAIL write_beat: got addr=%08h data=%08h, required addr=%08h data=%08h",
                             Write_Address, Write_Data, e[63:32], e[31:0]);
                end
            end
            n_cmp++;
            if (Byte_Ready !== 1'b0) begin
                n_bad++;
                $display("FAIL ready_in_write: got %b, required 0", Byte_Ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // All tasks start and end at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        Byte_Valid = 1'b1;
        Byte_Data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (Byte_Ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept_timeout: byte %02h never accepted, required accept", b);
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_finish(input string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_finish_timeout: got busy=%b, required done or error", name, busy);
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic exp_done,
                                      input logic exp_err);
        n_cmp++;
        if ({Byte_Ready, Write_Enable, busy, done, error} !== {3'b000, exp_done, exp_err}) begin
            n_bad++;
            $display("FAIL %s_flags: got rdy=%b we=%b busy=%b done=%b err=%b, required 0 0 0 %b %b",
                     name, Byte_Ready, Write_Enable, busy, done, error, exp_done, exp_err);
        end
    endtask

    task automatic check_queue_empty(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_writes_missing: got %0d pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; Byte_Valid = 1'b0; Byte_Data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held", 1'b0, 1'b0);
        n_cmp++;
        if ({Write_Address, Write_Data} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr=%08h data=%08h, required 0 0",
                     Write_Address, Write_Data);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_release", 1'b0, 1'b0);
    endtask

    task automatic test_two_words();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                               8'h20, 8'h09, 8'h00, 8'h07};
        int w0;
        pulse_start();
        n_cmp++;
        if ({busy, Byte_Ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL two_words_start: got busy=%b rdy=%b, required 1 1", busy, Byte_Ready);
        end
        exp_q.push_back({32'h00400000, 32'h20080005});
        exp_q.push_back({32'h00400004, 32'h20090007});
        w0 = n_writes;
        for (int i = 0; i < 10; i++) begin
            send_byte(s[i]);
            if (i == 5 || i == 9) begin
                n_cmp++;
                if (Write_Enable !== 1'b1) begin
                    n_bad++;
                    $display("FAIL two_words_we_latency: got we=%b, required 1", Write_Enable);
                end
            end
        end
        Byte_Valid = 1'b0;
        wait_finish("two_words");
        check_idle_outputs("two_words_end", 1'b1, 1'b0);
        check_queue_empty("two_words");
        n_cmp++;
        if (n_writes - w0 != 2) begin
            n_bad++;
            $display("FAIL two_words_count: got %0d writes, required 2", n_writes - w0);
        end
    endtask

    task automatic test_zero_length();
        int w0 = n_writes;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        Byte_Valid = 1'b0;
        check_idle_outputs("zero_len", 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (n_writes != w0) begin
            n_bad++;
            $display("FAIL zero_len_writes: got %0d, required 0", n_writes - w0);
        end
    endtask

    task automatic test_overflow();
        int w0 = n_writes;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check_idle_outputs("overflow", 1'b0, 1'b1);
        Byte_Data = 8'hAA;
        repeat (4) @(posedge clk);
        #1;
        Byte_Valid = 1'b0;
        check_idle_outputs("overflow_hold", 1'b0, 1'b1);
        n_cmp++;
        if (n_writes != w0) begin
            n_bad++;
            $display("FAIL overflow_writes: got %0d, required 0", n_writes - w0);
        end
        pulse_start();
        n_cmp++;
        if ({busy, Byte_Ready, error, done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL overflow_restart: got busy=%b rdy=%b err=%b done=%b, required 1 1 0 0",
                     busy, Byte_Ready, error, done);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        Byte_Valid = 1'b0;
        check_idle_outputs("overflow_recover", 1'b1, 1'b0);
    endtask

    task automatic test_throttled();
        logic [7:0] d [4] = '{8'h8C, 8'h02, 8'h00, 8'h04};
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        exp_q.push_back({32'h00400000, 32'h8C020004});
        for (int i = 0; i < 4; i++) begin
            Byte_Valid = 1'b0;
            @(posedge clk); #1;
            send_byte(d[i]);
        end
        Byte_Valid = 1'b0;
        n_cmp++;
        if ({Write_Enable, Write_Address, Write_Data} !== {1'b1, 32'h00400000, 32'h8C020004}) begin
            n_bad++;
            $display("FAIL throttled_write: got we=%b addr=%08h data=%08h, required 1 00400000 8c020004",
                     Write_Enable, Write_Address, Write_Data);
        end
        wait_finish("throttled");
        check_idle_outputs("throttled_end", 1'b1, 1'b0);
        check_queue_empty("throttled");
    endtask

    task automatic test_reset_mid_load();
        int w0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h8C);
        send_byte(8'h02);
        Byte_Valid = 1'b0;
        w0 = n_writes;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("mid_reset_held", 1'b0, 1'b0);
        reset = 1'b1;
        Byte_Valid = 1'b1;
        Byte_Data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            Byte_Data = 8'(i + 3);
            n_cmp++;
            if ({Byte_Ready, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL mid_reset_ready: got rdy=%b busy=%b, required 0 0", Byte_Ready, busy);
            end
        end
        @(posedge clk); #1;
        Byte_Valid = 1'b0;
        check_idle_outputs("mid_reset_after", 1'b0, 1'b0);
        n_cmp++;
        if (n_writes != w0 || {Write_Address, Write_Data} !== 64'd0) begin
            n_bad++;
            $display("FAIL mid_reset_bus: got writes=%0d addr=%08h data=%08h, required 0 0 0",
                     n_writes - w0, Write_Address, Write_Data);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                               8'h20, 8'h09, 8'h00, 8'h07};
        pulse_start();
        exp_q.push_back({32'h00400000, 32'h20080005});
        exp_q.push_back({32'h00400004, 32'h20090007});
        for (int i = 0; i < 10; i++) begin
            send_byte(s[i]);
            if (i == 3) begin
                Byte_Valid = 1'b0;
                pulse_start();
            end
        end
        Byte_Valid = 1'b0;
        wait_finish("start_ignored");
        check_idle_outputs("start_ignored_end", 1'b1, 1'b0);
        check_queue_empty("start_ignored");
        pulse_start();
        n_cmp++;
        if ({busy, Byte_Ready, done} !== 3'b110) begin
            n_bad++;
            $display("FAIL restart_from_done: got busy=%b rdy=%b done=%b, required 1 1 0",
                     busy, Byte_Ready, done);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        Byte_Valid = 1'b0;
        check_idle_outputs("restart_done_end", 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_length();
        test_overflow();
        test_throttled();
        test_reset_mid_load();
        test_start_ignored();
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
